// File: rtl/snake_body_tracker.sv
// Snake body tracker: circular {x,y} body buffer with a serial self-collision scan per move.
// Optional build macro SNAKE_BOUNDS_CHECK_EN kills the snake on off-board candidates.
module snake_body_tracker #(
    parameter int BOARD_WIDTH  = 20,
    parameter int BOARD_HEIGHT = 20,
    parameter int ADDR_WIDTH   = 5,
    parameter int MAX_LEN      = 32,
    parameter int LEN_WIDTH    = 6,
    parameter int INIT_X       = 10,
    parameter int INIT_Y       = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  grow,
    input  logic [ADDR_WIDTH-1:0] next_head_x,
    input  logic [ADDR_WIDTH-1:0] next_head_y,
    output logic [ADDR_WIDTH-1:0] head_x,
    output logic [ADDR_WIDTH-1:0] head_y,
    output logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  step_done,
    output logic                  collision
);

    // state  | meaning
    // IDLE   | waiting for step
    // SCAN   | comparing candidate against body entry hp-i, one per cycle
    // COMMIT | advance hp and write the candidate as new head
    // DEAD   | collision seen, frozen until reset
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DEAD} state_t;

    localparam int PTR_W = $clog2(MAX_LEN);

`ifdef SNAKE_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_x_q [MAX_LEN];
    logic [ADDR_WIDTH-1:0] mem_y_q [MAX_LEN];
    logic [PTR_W-1:0]      hp_q, hp_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  n_q, n_d;
    logic [LEN_WIDTH-1:0]  i_q, i_d;
    logic [ADDR_WIDTH-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [ADDR_WIDTH-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
    logic                  g_q, g_d;
    logic                  step_done_q, step_done_d;
    logic                  collision_q, collision_d;
    logic                  mem_we;

    logic [LEN_WIDTH-1:0]  n_calc;
    logic [PTR_W-1:0]      scan_idx;
    logic                  match, scan_last, oob;

    // With grow the tail stays put and must be scanned; without grow it vacates.
    assign n_calc    = grow ? len_q : len_q - LEN_WIDTH'(1);
    assign scan_idx  = hp_q - i_q[PTR_W-1:0];
    assign match     = (mem_x_q[scan_idx] == cand_x_q) && (mem_y_q[scan_idx] == cand_y_q);
    assign scan_last = (i_q == n_q - LEN_WIDTH'(1));
    assign oob       = BoundsEn && ((32'(next_head_x) >= BOARD_WIDTH) ||
                                    (32'(next_head_y) >= BOARD_HEIGHT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (step) begin
                    if (oob)                 state_d = DEAD;
                    else if (n_calc == '0)   state_d = COMMIT;
                    else                     state_d = SCAN;
                end
            end
            SCAN: begin
                if (match)          state_d = DEAD;
                else if (scan_last) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            DEAD:    state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        head_x    = head_x_q;
        head_y    = head_y_q;
        length    = len_q;
        step_done = step_done_q;
        collision = collision_q;
    end

    always_comb begin
        hp_d        = hp_q;
        len_d       = len_q;
        n_d         = n_q;
        i_d         = i_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        g_d         = g_q;
        step_done_d = 1'b0;
        collision_d = collision_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    cand_x_d = next_head_x;
                    cand_y_d = next_head_y;
                    g_d      = grow;
                    n_d      = n_calc;
                    i_d      = '0;
                    if (oob) collision_d = 1'b1;
                end
            end
            SCAN: begin
                if (match) collision_d = 1'b1;
                else       i_d = i_q + LEN_WIDTH'(1);
            end
            COMMIT: begin
                hp_d        = hp_q + PTR_W'(1);
                mem_we      = 1'b1;
                head_x_d    = cand_x_q;
                head_y_d    = cand_y_q;
                step_done_d = 1'b1;
                if (g_q && (len_q < LEN_WIDTH'(MAX_LEN))) len_d = len_q + LEN_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                mem_x_q[k] <= ADDR_WIDTH'(INIT_X);
                mem_y_q[k] <= ADDR_WIDTH'(INIT_Y);
            end
            hp_q        <= '0;
            len_q       <= LEN_WIDTH'(1);
            n_q         <= '0;
            i_q         <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            head_x_q    <= ADDR_WIDTH'(INIT_X);
            head_y_q    <= ADDR_WIDTH'(INIT_Y);
            g_q         <= 1'b0;
            step_done_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (mem_we) begin
                mem_x_q[hp_d] <= cand_x_q;
                mem_y_q[hp_d] <= cand_y_q;
            end
            hp_q        <= hp_d;
            len_q       <= len_d;
            n_q         <= n_d;
            i_q         <= i_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            g_q         <= g_d;
            step_done_q <= step_done_d;
            collision_q <= collision_d;
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: queue-based body model, random walks plus directed corner cases.
// A second instance with MAX_LEN=4 exercises length saturation.
module tb_snake_body_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b0, grow = 1'b0;
    logic [4:0] nhx = '0, nhy = '0;
    logic [4:0] head_x, head_y;
    logic [5:0] length;
    logic       busy, step_done, collision;

    logic       s_step = 1'b0, s_grow = 1'b0;
    logic [4:0] s_nhx = '0, s_nhy = '0;
    logic [4:0] s_head_x, s_head_y;
    logic [2:0] s_length;
    logic       s_busy, s_step_done, s_collision;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {logic [4:0] x; logic [4:0] y;} cell_t;
    cell_t body[$];   // body[0] is the head, last element is the tail
    bit    model_dead;

    snake_body_tracker u_dut (
        .clk(clk), .reset(reset), .step(step), .grow(grow),
        .next_head_x(nhx), .next_head_y(nhy),
        .head_x(head_x), .head_y(head_y), .length(length),
        .busy(busy), .step_done(step_done), .collision(collision)
    );

    snake_body_tracker #(.MAX_LEN(4), .LEN_WIDTH(3)) u_sat (
        .clk(clk), .reset(reset), .step(s_step), .grow(s_grow),
        .next_head_x(s_nhx), .next_head_y(s_nhy),
        .head_x(s_head_x), .head_y(s_head_y), .length(s_length),
        .busy(s_busy), .step_done(s_step_done), .collision(s_collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; step = 1'b0; grow = 1'b0; s_step = 1'b0; s_grow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        body.delete();
        body.push_back(cell_t'{5'd10, 5'd10});
        model_dead = 1'b0;
    endtask

    // Expected outcome from the game rules: cells the snake still occupies after the move.
    task automatic predict(input cell_t c, input bit g, output int lat, output bit dead);
        int n;
        n    = g ? body.size() : body.size() - 1;
        lat  = n + 1;
        dead = 1'b0;
`ifdef SNAKE_BOUNDS_CHECK_EN
        if (c.x >= 20 || c.y >= 20) begin
            lat  = 0;
            dead = 1'b1;
        end
`endif
        if (!dead) begin
            for (int i = 0; i < n; i++) begin
                if (body[i] == c) begin
                    lat  = i + 1;
                    dead = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic do_step(input int x, input int y, input bit g, input bit garbage);
        cell_t c, old_head;
        int    lat, cnt, old_len;
        bit    dead;
        c.x      = 5'(x);
        c.y      = 5'(y);
        old_head = body[0];
        old_len  = body.size();
        lat      = 0;
        dead     = 1'b1;
        if (!model_dead) predict(c, g, lat, dead);
        @(negedge clk);
        step = 1'b1; grow = g; nhx = c.x; nhy = c.y;
        @(posedge clk); #1;
        step = 1'b0; grow = 1'b0;
        if (model_dead) begin
            repeat (3) @(posedge clk);
            #1;
            chk("dead_collision", 32'(collision), 1);
            chk("dead_busy", 32'(busy), 1);
            chk("dead_head_x", 32'(head_x), 32'(old_head.x));
            chk("dead_head_y", 32'(head_y), 32'(old_head.y));
            chk("dead_length", 32'(length), 32'(old_len));
            chk("dead_step_done", 32'(step_done), 0);
        end else begin
            cnt = 0;
            while (!(step_done || collision) && cnt < 80) begin
                if (garbage && busy) begin
                    step = 1'($urandom);
                    grow = 1'($urandom);
                    nhx  = 5'($urandom_range(0, 19));
                    nhy  = 5'($urandom_range(0, 19));
                end
                @(posedge clk); #1;
                step = 1'b0; grow = 1'b0;
                cnt++;
            end
            chk("latency", 32'(cnt), 32'(lat));
            if (dead) begin
                model_dead = 1'b1;
                chk("coll_flag", 32'(collision), 1);
                chk("coll_busy", 32'(busy), 1);
                chk("coll_head_x", 32'(head_x), 32'(old_head.x));
                chk("coll_head_y", 32'(head_y), 32'(old_head.y));
                chk("coll_length", 32'(length), 32'(old_len));
            end else begin
                body.push_front(c);
                if (!g || body.size() > 32) void'(body.pop_back());
                chk("head_x", 32'(head_x), 32'(c.x));
                chk("head_y", 32'(head_y), 32'(c.y));
                chk("length", 32'(length), 32'(body.size()));
                chk("step_done", 32'(step_done), 1);
                chk("busy_after", 32'(busy), 0);
                chk("no_collision", 32'(collision), 0);
                @(posedge clk); #1;
                chk("step_done_pulse", 32'(step_done), 0);
            end
        end
    endtask

    task automatic sat_step(input int x, input int y, input bit g);
        int cnt;
        @(negedge clk);
        s_step = 1'b1; s_grow = g; s_nhx = 5'(x); s_nhy = 5'(y);
        @(posedge clk); #1;
        s_step = 1'b0; s_grow = 1'b0;
        cnt = 0;
        while (!(s_step_done || s_collision) && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("sat_timeout", 32'(cnt < 40), 1);
    endtask

    initial begin
        int hx, hy, nx, ny;

        apply_reset();
        #1;
        chk("rst_head_x", 32'(head_x), 10);
        chk("rst_head_y", 32'(head_y), 10);
        chk("rst_length", 32'(length), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_collision", 32'(collision), 0);
        chk("rst_step_done", 32'(step_done), 0);

        // Saturation on the 4-deep instance, then tail advance after saturation
        for (int k = 0; k < 5; k++) sat_step(11 + k, 10, 1'b1);
        chk("sat_length", 32'(s_length), 4);
        chk("sat_head_x", 32'(s_head_x), 15);
        sat_step(11, 10, 1'b1);
        chk("sat_oldtail_free", 32'(s_collision), 0);
        chk("sat_length2", 32'(s_length), 4);
        chk("sat_head_x2", 32'(s_head_x), 11);
        sat_step(13, 10, 1'b1);
        chk("sat_tail_grow_coll", 32'(s_collision), 1);
        chk("sat_head_hold", 32'(s_head_x), 11);

        // Single step, then three growing steps (latencies 2,3,4)
        apply_reset();
        do_step(11, 10, 1'b0, 1'b0);
        do_step(12, 10, 1'b1, 1'b0);
        do_step(13, 10, 1'b1, 1'b0);
        do_step(14, 10, 1'b1, 1'b0);
        chk("grow_len4", 32'(length), 4);
        chk("grow_head", 32'(head_x), 14);

        // Tail chase in a 2x2 loop: legal without grow, fatal with grow
        apply_reset();
        do_step(11, 10, 1'b1, 1'b0);
        do_step(11, 11, 1'b1, 1'b0);
        do_step(10, 11, 1'b1, 1'b0);
        do_step(10, 10, 1'b0, 1'b0);
        chk("chase_ok", 32'(collision), 0);
        do_step(11, 10, 1'b1, 1'b0);
        chk("chase_grow_dead", 32'(collision), 1);
        do_step(11, 11, 1'b0, 1'b0);

        // Self-collision into a mid-body cell at length 5
        apply_reset();
        do_step(11, 10, 1'b1, 1'b1);
        do_step(12, 10, 1'b1, 1'b1);
        do_step(12, 11, 1'b1, 1'b1);
        do_step(11, 11, 1'b1, 1'b1);
        chk("mid_len5", 32'(length), 5);
        do_step(11, 10, 1'b0, 1'b1);
        chk("mid_dead", 32'(collision), 1);
        do_step(10, 11, 1'b0, 1'b0);

        // Reset in the middle of a scan aborts the move
        apply_reset();
        do_step(11, 10, 1'b1, 1'b0);
        do_step(12, 10, 1'b1, 1'b0);
        @(negedge clk);
        step = 1'b1; grow = 1'b1; nhx = 5'd13; nhy = 5'd10;
        @(posedge clk); #1;
        step = 1'b0; grow = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("abort_head_x", 32'(head_x), 10);
        chk("abort_length", 32'(length), 1);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        body.delete();
        body.push_back(cell_t'{5'd10, 5'd10});
        model_dead = 1'b0;
        do_step(11, 10, 1'b0, 1'b0);

        // Off-board candidate
        apply_reset();
        do_step(20, 3, 1'b0, 1'b0);

        // Random walk with wrap, random grow and ignored mid-move steps
        apply_reset();
        for (int m = 0; m < 150; m++) begin
            if (model_dead) begin
                do_step($urandom_range(0, 19), $urandom_range(0, 19), 1'($urandom), 1'b0);
                apply_reset();
            end else begin
                hx = int'(body[0].x);
                hy = int'(body[0].y);
                nx = hx;
                ny = hy;
                case ($urandom_range(0, 3))
                    0:       nx = (hx + 1) % 20;
                    1:       nx = (hx + 19) % 20;
                    2:       ny = (hy + 1) % 20;
                    default: ny = (hy + 19) % 20;
                endcase
                do_step(nx, ny, ($urandom_range(0, 2) == 0), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_body_tracker.md
SNAKE_BODY_TRACKER -- requirements
Module: snake_body_tracker

Interface
REQ-001 Parameters SHALL be:
- BOARD_WIDTH, default 20, columns.
- BOARD_HEIGHT, default 20, rows.
- ADDR_WIDTH, default 5, coordinate width.
- MAX_LEN, default 32, body capacity, power of 2, at least 2.
- LEN_WIDTH, default 6, length width, holds MAX_LEN.
- INIT_X, default 10, reset head column.
- INIT_Y, default 10, reset head row.
REQ-002 Ports SHALL be:
- clk, in, 1, the single clock; all flops on rising edge.
- reset, in, 1, asynchronous active-low reset.
- step, in, 1, advance request.
- grow, in, 1, food eaten; sampled with step.
- next_head_x, in, ADDR_WIDTH, candidate head column from move logic.
- next_head_y, in, ADDR_WIDTH, candidate head row.
- head_x, out, ADDR_WIDTH, current head column; feeds move logic.
- head_y, out, ADDR_WIDTH, current head row.
- length, out, LEN_WIDTH, segment count.
- busy, out, 1, high whenever state is not IDLE.
- step_done, out, 1, one-cycle pulse after a committed move.
- collision, out, 1, sticky game over.

Function
REQ-003 Body storage SHALL be a circular buffer of MAX_LEN {x,y} entries with head pointer hp; the tail is implicit at hp-length+1 mod MAX_LEN.
REQ-004 The FSM SHALL have states IDLE, SCAN, COMMIT and DEAD.
REQ-005 IDLE with step=1 SHALL latch next_head_x/y, latch grow as g, and set N = g ? length : length-1.
REQ-006 From IDLE, N=0 SHALL go to COMMIT; otherwise to SCAN with i=0.
REQ-007 In IDLE, step=0 SHALL hold all state.
REQ-008 SCAN SHALL compare the candidate against entry hp-i, one entry per cycle, for i=0..N-1.
REQ-009 On a match, SCAN SHALL go to DEAD and set collision=1; after i=N-1 with no match it SHALL go to COMMIT.
REQ-010 The tail cell SHALL be excluded when g=0, because it vacates: moving into the tail is legal without grow and fatal with grow.
REQ-011 COMMIT SHALL:
- set hp to hp+1 mod MAX_LEN;
- write the candidate at the new hp;
- set length+1 if g=1 and length<MAX_LEN, else leave it unchanged;
- return to IDLE.
REQ-012 Grow at length=MAX_LEN SHALL saturate length, and the tail SHALL advance.
REQ-013 Latency: with step sampled at edge E0, head_x/head_y/length SHALL update at edge E0+N+1, and step_done SHALL be high for exactly the cycle following that edge.
REQ-014 step while busy=1 SHALL be ignored, with no queueing.
REQ-015 grow SHALL be ignored when step is not accepted.
REQ-016 DEAD SHALL ignore step and grow and hold every output, with collision=1 and busy=1; only reset exits it.
REQ-017 head_x/head_y SHALL always equal entry hp, driven from registers.

Reset
REQ-018 reset low SHALL asynchronously force:
- state=IDLE, hp=0;
- entry 0 = {INIT_X, INIT_Y};
- head_x=INIT_X, head_y=INIT_Y;
- length=1;
- busy=0, step_done=0, collision=0.
REQ-019 Reset asserted mid-SCAN or mid-COMMIT SHALL abort the move with no buffer write.
REQ-020 Release SHALL be synchronous-safe: the first step is accepted at the first rising edge after reset goes high.

Configuration
REQ-021 With SNAKE_BOUNDS_CHECK_EN defined, a step accepted in IDLE whose candidate has x>=BOARD_WIDTH or y>=BOARD_HEIGHT SHALL go directly to DEAD with collision=1 on the next edge, skipping SCAN.
REQ-022 Without SNAKE_BOUNDS_CHECK_EN, candidates SHALL be accepted unchecked, since move logic guarantees wrap.

Verification
REQ-023 Reset test: after reset release, outputs SHALL read head=(10,10), length=1, busy=0, collision=0.
REQ-024 Single step: step with (11,10), grow=0 gives N=0, so head=(11,10) one edge later, step_done pulses once, and length=1.
REQ-025 Growth latency: three east steps with grow=1 SHALL reach length=4, head=(14,10), with update latencies of 2, 3 and 4 edges.
REQ-026 Self-collision: at length 5, stepping into a mid-body cell SHALL set collision=1 and busy=1 with head unchanged; a later step has no effect.
REQ-027 Tail-chase: at length 4 in a 2x2 loop, a step into the tail cell with grow=0 SHALL commit, while the same step with grow=1 SHALL set collision.
REQ-028 Saturation and bounds:
- With MAX_LEN=4, a fifth grow SHALL keep length=4.
- With SNAKE_BOUNDS_CHECK_EN, candidate (20,3) SHALL set collision on the next edge.
